// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    localparam int NDIGITS = 8;

    typedef logic [2:0] digit_idx_t;

    // One full display image; used for both the shadow and active copies.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dot;
        logic [7:0]  en;
    } disp_cfg_t;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NDIGITS-1:0] an_sel(input digit_idx_t i);
        logic [NDIGITS-1:0] one;
        one = {{(NDIGITS-1){1'b0}}, 1'b1};
        return ~(one << i);
    endfunction

endpackage

// File: rtl/seg7.sv
// Hex nibble to active-low seven-segment pattern {dp_n, g..a}; purely combinational.
module seg7 (
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph = 7'h7F;
        unique case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    end

    assign seg = {~dot, glyph};

endmodule

// File: rtl/seg7_scan.sv
// 8-digit multiplexed seven-segment scanner with frame-synchronous double buffering.
// Optional per-digit blinking is enabled by defining SEG7_SCAN_BLINK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dot_mask,
    input  logic [7:0]  en_mask,
    input  logic [7:0]  blink_mask,
    output logic        pending,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]      pcnt;
    logic               tick;
    logic               fb;
    digit_idx_t         idx;
    disp_cfg_t          shadow;
    disp_cfg_t          active;
    logic [NDIGITS-1:0] vis;
    logic [3:0]         cur_nib;
    logic               cur_dot;
    logic [7:0]         seg_dec;

    assign tick = (pcnt == PW'(DIV - 1));
    assign fb   = tick && (idx == digit_idx_t'(NDIGITS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
        end
    end

    // A load coinciding with fb lands in shadow while the old shadow commits,
    // so pending must stay set in that case.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (fb && pending)
                active <= shadow;
            if (load) begin
                shadow  <= '{data: data, dot: dot_mask, en: en_mask};
                pending <= 1'b1;
            end else if (fb) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SEG7_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt;
    logic          phase;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (fb) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // blink_mask is taken live so user logic can start/stop blinking instantly.
    assign vis = active.en & ~(blink_mask & {NDIGITS{phase}});
`else
    logic unused_blink;

    assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
    assign vis          = active.en;
`endif

    assign cur_nib = active.data[{idx, 2'b00} +: 4];
    assign cur_dot = active.dot[idx];

    seg7 u_dec (
        .nibble (cur_nib),
        .dot    (cur_dot),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (vis[idx]) begin
            an  <= an_sel(idx);
            seg <= seg_dec;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end
    end

endmodule
